// File: rtl/scanlines.sv
// Scanline dimming stage: darkens every other video line by a
// frame-latched strength, blanks colour, delays syncs one pixel.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   pix_ce          : pixel enable; all state moves only when high
//   mode[1:0]       : requested strength (0 off, 1 75%, 2 50%, 3 25%)
//   hblank, vblank  : blanking in
//   hs, vs          : syncs in
//   red/green/blue  : 6-bit colour in
//   *_out           : registered copies / processed colour, 1 pixel late
module scanlines (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_ce,
   input  logic [1:0] mode,
   input  logic       hblank,
   input  logic       vblank,
   input  logic       hs,
   input  logic       vs,
   input  logic [5:0] red,
   input  logic [5:0] green,
   input  logic [5:0] blue,
   output logic       hblank_out,
   output logic       vblank_out,
   output logic       hs_out,
   output logic       vs_out,
   output logic [5:0] red_out,
   output logic [5:0] green_out,
   output logic [5:0] blue_out
);

   logic       r_hs_d;
   logic       r_vs_d;
   logic       r_parity;
   logic [1:0] r_active_mode;

   logic       w_hs_rise;
   logic       w_vs_rise;
   logic       w_blank;
   logic [5:0] w_red;
   logic [5:0] w_green;
   logic [5:0] w_blue;

   // Colour uses the parity/mode as they stand before this
   // cycle's sync edges update them.
   function automatic logic [5:0] f_dim(
      input logic [5:0] c,
      input logic       par,
      input logic [1:0] m,
      input logic       blank
   );
      logic [5:0] res;
      res = c;
      if (blank) begin
         res = 6'd0;
      end else if (par) begin
         case (m)
            2'd1:    res = c - (c >> 2);
            2'd2:    res = c >> 1;
            2'd3:    res = c >> 2;
            default: res = c;
         endcase
      end
      return res;
   endfunction

   assign w_hs_rise = hs & ~r_hs_d;
   assign w_vs_rise = vs & ~r_vs_d;
   assign w_blank   = hblank | vblank;

   assign w_red   = f_dim(red,   r_parity, r_active_mode, w_blank);
   assign w_green = f_dim(green, r_parity, r_active_mode, w_blank);
   assign w_blue  = f_dim(blue,  r_parity, r_active_mode, w_blank);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hs_d        <= 1'b0;
         r_vs_d        <= 1'b0;
         r_parity      <= 1'b0;
         r_active_mode <= 2'd0;
         hblank_out    <= 1'b0;
         vblank_out    <= 1'b0;
         hs_out        <= 1'b0;
         vs_out        <= 1'b0;
         red_out       <= 6'd0;
         green_out     <= 6'd0;
         blue_out      <= 6'd0;
      end else if (pix_ce) begin
         r_hs_d     <= hs;
         r_vs_d     <= vs;
         hblank_out <= hblank;
         vblank_out <= vblank;
         hs_out     <= hs;
         vs_out     <= vs;
         red_out    <= w_red;
         green_out  <= w_green;
         blue_out   <= w_blue;
         // Frame start wins over line start so every frame
         // begins on an undimmed line.
         if (w_vs_rise) begin
            r_parity      <= 1'b0;
            r_active_mode <= mode;
         end else if (w_hs_rise) begin
            r_parity <= ~r_parity;
         end
      end
   end

endmodule

// File: tb/tb_scanlines.sv
// Directed bench for scanlines: latency, dimming pattern, mode
// latching, blanking, pix_ce gating and mid-frame reset.
module tb_scanlines;

   logic       clk;
   logic       reset;
   logic       pix_ce;
   logic [1:0] mode;
   logic       hblank;
   logic       vblank;
   logic       hs;
   logic       vs;
   logic [5:0] red;
   logic [5:0] green;
   logic [5:0] blue;
   logic       hblank_out;
   logic       vblank_out;
   logic       hs_out;
   logic       vs_out;
   logic [5:0] red_out;
   logic [5:0] green_out;
   logic [5:0] blue_out;

   int n_checks = 0;
   int n_errors = 0;

   scanlines dut (
      .clk(clk), .reset(reset), .pix_ce(pix_ce), .mode(mode),
      .hblank(hblank), .vblank(vblank), .hs(hs), .vs(vs),
      .red(red), .green(green), .blue(blue),
      .hblank_out(hblank_out), .vblank_out(vblank_out),
      .hs_out(hs_out), .vs_out(vs_out),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One clock; inputs change 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic hb, input logic vb, input logic h,
                      input logic v, input logic [5:0] c);
      hblank = hb; vblank = vb; hs = h; vs = v;
      red = c; green = c; blue = c;
   endtask

   task automatic vs_pulse();
      drv(1'b1, 1'b1, 1'b0, 1'b1, 6'd0); cyc();
      drv(1'b1, 1'b1, 1'b0, 1'b0, 6'd0); cyc();
   endtask

   task automatic hs_pulse();
      drv(1'b1, 1'b0, 1'b1, 1'b0, 6'd0); cyc();
      drv(1'b1, 1'b0, 1'b0, 1'b0, 6'd0); cyc();
   endtask

   task automatic pix(input string tag, input logic [5:0] c,
                      input int exp);
      drv(1'b0, 1'b0, 1'b0, 1'b0, c); cyc();
      check(tag, red_out, exp);
   endtask

   initial begin
      reset = 1'b1; pix_ce = 1'b1; mode = 2'd0;
      drv(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      cyc(); cyc();
      check("rst_red", red_out, 0);
      check("rst_hs", hs_out, 0);
      check("rst_vb", vblank_out, 0);
      reset = 1'b0;

      // latency
      pix("lat_red40", 6'd40, 40);
      drv(1'b1, 1'b0, 1'b1, 1'b0, 6'd0); cyc();
      check("lat_hs", hs_out, 1);
      check("lat_hb", hblank_out, 1);
      drv(1'b1, 1'b1, 1'b0, 1'b1, 6'd0); cyc();
      check("lat_vs", vs_out, 1);
      check("lat_vb", vblank_out, 1);
      check("lat_hs0", hs_out, 0);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 6'd0); cyc();

      // pattern at mode 2
      mode = 2'd2;
      vs_pulse();
      pix("m2_l0", 6'd63, 63);
      hs_pulse();
      pix("m2_l1", 6'd63, 31);
      drv(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      red = 6'd40; green = 6'd20; blue = 6'd63; cyc();
      check("m2_l1_r", red_out, 20);
      check("m2_l1_g", green_out, 10);
      check("m2_l1_b", blue_out, 31);
      hs_pulse();
      pix("m2_l2", 6'd63, 63);
      hs_pulse();
      pix("m2_l3", 6'd63, 31);

      // mode latching
      mode = 2'd3;
      vs_pulse();
      pix("m3_l0", 6'd63, 63);
      hs_pulse();
      pix("m3_l1", 6'd63, 15);
      mode = 2'd1;
      hs_pulse();
      pix("m3_l2", 6'd63, 63);
      hs_pulse();
      pix("m3_l3_held", 6'd63, 15);
      vs_pulse();
      pix("m1_l0", 6'd63, 63);
      hs_pulse();
      pix("m1_l1", 6'd63, 48);

      // blanking on an odd line, then coincident edges
      drv(1'b1, 1'b0, 1'b0, 1'b0, 6'd63); cyc();
      check("hblank_zero", red_out, 0);
      drv(1'b0, 1'b1, 1'b0, 1'b0, 6'd63); cyc();
      check("vblank_zero", blue_out, 0);
      drv(1'b1, 1'b1, 1'b1, 1'b1, 6'd0); cyc();
      drv(1'b1, 1'b1, 1'b0, 1'b0, 6'd0); cyc();
      pix("hsvs_par0", 6'd63, 63);

      // pix_ce gating, every 4th clock enabled
      pix_ce = 1'b0;
      drv(1'b0, 1'b0, 1'b0, 1'b0, 6'd20);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("ce_hold_red", red_out, 63);
      end
      pix_ce = 1'b1; cyc();
      check("ce_on_red", red_out, 20);
      drv(1'b1, 1'b0, 1'b1, 1'b0, 6'd0); cyc();
      check("ce_hs_up", hs_out, 1);
      pix_ce = 1'b0;
      drv(1'b0, 1'b0, 1'b1, 1'b0, 6'd33);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("ce_hold_hb", hblank_out, 1);
      end
      drv(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
      pix_ce = 1'b1; cyc();
      check("ce_hs_held", hs_out, 1);
      pix_ce = 1'b0;
      drv(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
      cyc(); cyc(); cyc();
      pix_ce = 1'b1; cyc();
      check("ce_hs_dn", hs_out, 0);
      pix("ce_one_toggle", 6'd63, 48);

      // reset mid odd line, with pix_ce low to show priority
      reset = 1'b1; pix_ce = 1'b0;
      drv(1'b0, 1'b0, 1'b0, 1'b0, 6'd63); cyc();
      check("mrst_red", red_out, 0);
      check("mrst_grn", green_out, 0);
      reset = 1'b0; pix_ce = 1'b1;
      pix("mrst_l0", 6'd63, 63);
      hs_pulse();
      pix("mrst_l1_m0", 6'd63, 63);
      mode = 2'd2;
      hs_pulse();
      pix("mrst_l2_m0", 6'd63, 63);
      hs_pulse();
      pix("mrst_l3_m0", 6'd63, 63);
      vs_pulse();
      pix("mrst_f_l0", 6'd63, 63);
      hs_pulse();
      pix("mrst_f_l1", 6'd63, 31);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/scanlines.md
SCANLINES -- requirements
Module: scanlines

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset; one clock; sampled on rising clk edge.
REQ-003 SHALL have port: pix_ce  input  1  pixel clock enable; state advances only on clk edges where pix_ce=1.
REQ-004 SHALL have port: mode  input  2  scanline strength request: 0 off, 1 = 75%, 2 = 50%, 3 = 25% brightness.
REQ-005 SHALL have ports: hblank, vblank, hs, vs  input  1 each  blanking/sync from the upstream composite-blend stage.
REQ-006 SHALL have ports: red, green, blue  input  6 each  pixel colour from the upstream composite-blend stage.
REQ-007 SHALL have ports: hblank_out, vblank_out, hs_out, vs_out  output  1 each  registered, delayed copies of the inputs.
REQ-008 SHALL have ports: red_out, green_out, blue_out  output  6 each  registered, processed colour.

Function
REQ-009 SHALL register all outputs and internal state only on clk edges with pix_ce=1, except reset.
REQ-010 SHALL give every output exactly 1 pix_ce-qualified cycle of latency relative to its inputs.
REQ-011 SHALL keep registers hs_d and vs_d, holding hs and vs from the previous enabled cycle.
REQ-012 SHALL detect an hs rising edge as hs=1 and hs_d=0, and a vs rising edge as vs=1 and vs_d=0, both in the same enabled cycle.
REQ-013 SHALL keep a 1-bit line parity register; it toggles on each hs rising edge.
REQ-014 SHALL clear line parity to 0 on a vs rising edge; when hs and vs rising edges coincide, vs wins and parity becomes 0.
REQ-015 SHALL keep a 2-bit active_mode register, loaded from mode only on a vs rising edge.
REQ-016 SHALL NOT change active_mode mid-frame: mode changes take effect from the frame after the next vs rising edge.
REQ-017 SHALL compute colour output per channel from the current-cycle input colour c and current (pre-update) parity and active_mode.
REQ-018 SHALL pass c unchanged when parity=0 or active_mode=0.
REQ-019 SHALL, when parity=1: output c - (c>>2) for active_mode=1, c>>1 for active_mode=2, and c>>2 for active_mode=3.
REQ-020 SHALL use 6-bit unsigned arithmetic with truncating shifts; results never overflow or underflow (max 63 -> 48/31/15).
REQ-021 SHALL force red_out/green_out/blue_out to 0 when input hblank=1 or vblank=1, regardless of parity or mode.
REQ-022 SHALL hold all outputs and state unchanged on cycles where pix_ce=0 and reset=0.
REQ-023 SHALL apply identical processing to all three channels in the same cycle.

Reset
REQ-024 SHALL give reset priority over pix_ce; reset acts on any clk edge where reset=1.
REQ-025 SHALL, on reset, clear all outputs, hs_d, vs_d, parity and active_mode to 0.
REQ-026 SHALL, on reset asserted mid-line or mid-frame, discard in-progress parity; first post-reset line has parity 0, and mode stays 0 (passthrough) until the first vs rising edge.

Verification
REQ-027 SHALL verify latency: pix_ce=1 constantly, mode=0, frame with red=40 -> red_out=40 exactly one clk later; syncs and blanks delayed one clk.
REQ-028 SHALL verify scanline pattern: mode=2, vs pulse, then lines of red=green=blue=63 -> line 0 outputs 63, line 1 outputs 31, line 2 outputs 63, alternating.
REQ-029 SHALL verify mode latching: mode changed 3->1 mid-frame after a vs edge with mode=3 -> odd lines stay at 15 for input 63 until the next vs edge, then 48.
REQ-030 SHALL verify blanking and edge precedence: input 63 with hblank=1 gives 0 out; hs and vs rising in the same enabled cycle -> following line uses parity 0 (passes 63 unchanged).
REQ-031 SHALL verify pix_ce gating: pix_ce=1 every 4th clk -> outputs change only on those edges; hs held high across disabled cycles counts as one edge, so parity toggles once.
REQ-032 SHALL verify reset mid-frame: reset for 1 clk during an odd line -> all outputs 0 next clk, then passthrough of 63 at mode 0 until the next vs rising edge.
